multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the single-datapath CPU. Decodes the latched instruction word and ALU status flags, then drives the datapath control strobes (PCSel, EnWri, ALUsrc, WB, MRW, IMMXSel) plus PC/IR enables and ALU operation, one phase per clock. It supports an RV32I subset: R-type ALU, I-type ALU, LW, SW, and BEQ/BNE/BLT/BGE.

---
 rtl/multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control sequencer for the single-datapath RV32I-subset CPU.
// Sequences FETCH/DECODE/EXEC/MEM/WBK phases and drives datapath strobes combinationally
// from the current state, the latched instruction and (in branch EXEC only) the ALU flags.
// Optional build macro ILLEGAL_TRAP_EN: illegal instructions enter a sticky TRAP state
// instead of retiring as NOPs.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_i,
  input  logic [31:0] instr_i,
  input  logic [3:0]  status_i,
  output logic        pcen_o,
  output logic        iren_o,
  output logic        pcsel_o,
  output logic        enwri_o,
  output logic        alusrc_o,
  output logic        wb_o,
  output logic        mrw_o,
  output logic [1:0]  immxsel_o,
  output logic [3:0]  aluctl_o,
  output logic [2:0]  state_o,
  output logic        illegal_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WBK    = 3'b100,
    S_TRAP   = 3'b111
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_r, is_i, is_ld, is_st, is_br;
  logic       legal;
  logic       taken;
  logic [3:0] alu_op;
  logic [1:0] immx_dec;

  logic pcen, iren, pcsel, enwri, alusrc, wb, mrw, illegal;
  logic [1:0] immx;
  logic [3:0] aluctl;

  // Register/immediate fields and the carry flag play no part in sequencing.
  logic unused_fields;
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7], status_i[1]};

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_ld  = (opcode == OP_LW);
  assign is_st  = (opcode == OP_SW);
  assign is_br  = (opcode == OP_BR);

  // Instruction decode: legality, ALU operation, immediate format, branch outcome.
  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      is_r:  legal = (funct7 == 7'b0000000) ||
                     ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      is_i:  legal = (funct3 != 3'b101) || (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
      is_ld: legal = (funct3 == 3'b010);
      is_st: legal = (funct3 == 3'b010);
      is_br: legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                     (funct3 == 3'b100) || (funct3 == 3'b101);
      default: legal = 1'b0;
    endcase

    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLT;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase

    immx_dec = 2'b00;
    if (is_st) immx_dec = 2'b01;
    else if (is_br) immx_dec = 2'b10;

    // Status is {N,Z,C,V}
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = status_i[2];
      3'b001:  taken = ~status_i[2];
      3'b100:  taken = status_i[3] ^ status_i[0];
      3'b101:  taken = ~(status_i[3] ^ status_i[0]);
      default: taken = 1'b0;
    endcase
  end

  // Next-state and MEM wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH:  if (run_i) state_d = S_DECODE;
      S_DECODE: begin
        if (legal) state_d = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
        else state_d = S_TRAP;
`else
        else state_d = S_FETCH;
`endif
      end
      S_EXEC: begin
        if (is_ld || is_st) begin
          cnt_d   = 4'(MEM_WAIT);
          state_d = S_MEM;
        end else if (is_br) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_WBK;
        end
      end
      S_MEM: begin
        if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
        else state_d = is_ld ? S_WBK : S_FETCH;
      end
      S_WBK:  state_d = S_FETCH;
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    pcen    = 1'b0;
    iren    = 1'b0;
    pcsel   = 1'b0;
    enwri   = 1'b0;
    alusrc  = 1'b0;
    wb      = 1'b1;
    mrw     = 1'b0;
    immx    = immx_dec;
    aluctl  = ALU_ADD;
    illegal = 1'b0;
    case (state_q)
      S_FETCH: begin
        immx = 2'b00;
        iren = run_i;
      end
      S_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
        if (!legal) pcen = 1'b1;
`endif
      end
      S_EXEC: begin
        if (is_br) begin
          aluctl = ALU_SUB;
          pcen   = 1'b1;
          pcsel  = taken;
        end else if (is_ld || is_st) begin
          alusrc = 1'b1;
        end else begin
          alusrc = is_i;
          aluctl = alu_op;
        end
      end
      S_MEM: begin
        if ((cnt_q == '0) && is_st) begin
          mrw  = 1'b1;
          pcen = 1'b1;
        end
      end
      S_WBK: begin
        enwri = 1'b1;
        pcen  = 1'b1;
        wb    = ~is_ld;
      end
      S_TRAP: begin
        immx    = 2'b00;
        illegal = 1'b1;
      end
      default: immx = 2'b00;
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write-side strobes are gated so a reset aborts with no side effects.
  assign pcen_o    = pcen & rst_n;
  assign iren_o    = iren & rst_n;
  assign enwri_o   = enwri & rst_n;
  assign mrw_o     = mrw & rst_n;
  assign pcsel_o   = pcsel;
  assign alusrc_o  = alusrc;
  assign wb_o      = wb;
  assign immxsel_o = immx;
  assign aluctl_o  = aluctl;
  assign state_o   = state_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_o = illegal;
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: two instances (MEM_WAIT=0 and MEM_WAIT=2) checked cycle by
// cycle against a phase-list reference model, with a directed vector table, a reset-abort
// sequence and randomized instructions.
module tb_multicycle_ctrl;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_ILL = 5;
  localparam logic [3:0] ALU_BASE [8] = '{4'd0, 4'd5, 4'd8, 4'd8, 4'd4, 4'd6, 4'd3, 4'd2};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_a, run_b;
  logic [31:0] instr;
  logic [3:0]  status;
  // Packed observation: {state[2:0], pcen, iren, pcsel, enwri, alusrc, wb, mrw, immx[1:0], alu[3:0], illegal}
  wire  [16:0] oa, ob;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .run_i(run_a), .instr_i(instr), .status_i(status),
    .pcen_o(oa[13]), .iren_o(oa[12]), .pcsel_o(oa[11]), .enwri_o(oa[10]),
    .alusrc_o(oa[9]), .wb_o(oa[8]), .mrw_o(oa[7]), .immxsel_o(oa[6:5]),
    .aluctl_o(oa[4:1]), .state_o(oa[16:14]), .illegal_o(oa[0])
  );

  multicycle_ctrl #(.MEM_WAIT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .run_i(run_b), .instr_i(instr), .status_i(status),
    .pcen_o(ob[13]), .iren_o(ob[12]), .pcsel_o(ob[11]), .enwri_o(ob[10]),
    .alusrc_o(ob[9]), .wb_o(ob[8]), .mrw_o(ob[7]), .immxsel_o(ob[6:5]),
    .aluctl_o(ob[4:1]), .state_o(ob[16:14]), .illegal_o(ob[0])
  );

  function automatic int kind_of(input logic [31:0] ins);
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    case (op)
      7'h33: return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? K_R : K_ILL;
      7'h13: return (f3 != 3'd5 || f7 == 7'h00 || f7 == 7'h20) ? K_I : K_ILL;
      7'h03: return (f3 == 3'd2) ? K_LW : K_ILL;
      7'h23: return (f3 == 3'd2) ? K_SW : K_ILL;
      7'h63: return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5) ? K_BR : K_ILL;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] alu_exp(input logic [31:0] ins);
    int k = kind_of(ins);
    logic [2:0] f3 = ins[14:12];
    logic [3:0] a = ALU_BASE[f3];
    if (ins[31:25] == 7'h20 && ((k == K_R && f3 == 3'd0) || f3 == 3'd5)) a = a + 4'd1;
    return a;
  endfunction

  function automatic logic taken_exp(input logic [31:0] ins, input logic [3:0] st);
    logic lt = st[3] ^ st[0];
    case (ins[14:12])
      3'd0: return st[2];
      3'd1: return !st[2];
      3'd4: return lt;
      3'd5: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs for one phase (phase number = spec state code).
  function automatic logic [16:0] exp_vec(input int ph, input logic [31:0] ins, input logic [3:0] st,
                                          input logic run, input bit last_mem);
    int k = kind_of(ins);
    logic pcen = 0, iren = 0, pcsel = 0, enwri = 0, alusrc = 0, wb = 1, mrw = 0, ill = 0;
    logic [1:0] immx = 2'b00;
    logic [3:0] alu = 4'd0;
    logic [2:0] s = 3'(ph);
    if (ph != 0 && ph != 7) immx = (ins[6:0] == 7'h23) ? 2'b01 : (ins[6:0] == 7'h63) ? 2'b10 : 2'b00;
    case (ph)
      0: iren = run;
      1: if (k == K_ILL && !TRAP) pcen = 1;
      2: begin
        if (k == K_R) alu = alu_exp(ins);
        else if (k == K_I) begin alusrc = 1; alu = alu_exp(ins); end
        else if (k == K_LW || k == K_SW) alusrc = 1;
        else if (k == K_BR) begin alu = 4'd1; pcen = 1; pcsel = taken_exp(ins, st); end
      end
      3: if (last_mem && k == K_SW) begin mrw = 1; pcen = 1; end
      4: begin enwri = 1; pcen = 1; wb = (k != K_LW); end
      7: ill = 1;
      default: ;
    endcase
    return {s, pcen, iren, pcsel, enwri, alusrc, wb, mrw, immx, alu, ill};
  endfunction

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%h expected=%h (instr=%h status=%h t=%0t)", name, got, exp, instr, status, $time);
    end
  endtask

  task automatic set_run(input bit on_b, input logic v);
    if (on_b) run_b = v; else run_a = v;
  endtask

  // Run one instruction from FETCH on the chosen instance, comparing every cycle.
  // Entered and left at posedge+1.
  task automatic run_instr(input bit on_b, input logic [31:0] ins, input logic [3:0] st,
                           input int exp_cycles, input bit chk_exec,
                           input logic [3:0] exec_alu, input logic exec_pcsel);
    int q[$];
    int k = kind_of(ins);
    int mw = on_b ? 2 : 0;
    int measured = -1;
    int final_ph;
    logic [16:0] obs;
    q.push_back(0); q.push_back(1);
    case (k)
      K_R, K_I: begin q.push_back(2); q.push_back(4); end
      K_BR: q.push_back(2);
      K_LW: begin q.push_back(2); for (int j = 0; j <= mw; j++) q.push_back(3); q.push_back(4); end
      K_SW: begin q.push_back(2); for (int j = 0; j <= mw; j++) q.push_back(3); end
      default: if (TRAP) begin q.push_back(7); q.push_back(7); q.push_back(7); end
    endcase
    final_ph = (k == K_ILL && TRAP) ? 7 : 0;
    instr  = ins;
    status = st;
    for (int i = 0; i <= q.size(); i++) begin
      logic r = (i == 0) ? 1'b1 : (i < q.size()) ? 1'($urandom) : 1'b0;
      set_run(on_b, r);
      @(negedge clk);
      obs = on_b ? ob : oa;
      if (i > 0 && measured < 0 && obs[16:14] == 3'd0) measured = i;
      if (i < q.size()) begin
        bit last = (q[i] == 3) && ((i + 1 == q.size()) || (q[i+1] != 3));
        check($sformatf("cyc%0d_ph%0d", i, q[i]), obs, exp_vec(q[i], ins, st, r, last));
        if (i == 2 && chk_exec)
          check("exec_alu_pcsel", {12'd0, obs[4:1], obs[11]}, {12'd0, exec_alu, exec_pcsel});
      end else begin
        check("end_state", obs, exp_vec(final_ph, ins, st, 1'b0, 1'b0));
      end
      @(posedge clk); #1;
    end
    if (exp_cycles >= 0) check("cycles", 17'(measured), 17'(exp_cycles));
    if (final_ph == 7) begin
      rst_n = 1'b0;
      #2;
      check("trap_reset", on_b ? ob : oa, exp_vec(0, ins, st, 1'b0, 1'b0));
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  st;
    bit          on_b;
    int          cyc;
    bit          chk;
    logic [3:0]  alu;
    logic        pcsel;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0; run_a = 1'b0; run_b = 1'b0; instr = '0; status = '0;

    tbl.push_back('{32'h002081B3, 4'b0000, 1'b0, 4, 1'b1, 4'd0, 1'b0}); // ADD
    tbl.push_back('{32'h00802283, 4'b0000, 1'b1, 7, 1'b1, 4'd0, 1'b0}); // LW, wait 2
    tbl.push_back('{32'h00502623, 4'b0000, 1'b0, 4, 1'b1, 4'd0, 1'b0}); // SW, wait 0
    tbl.push_back('{32'h00208463, 4'b0100, 1'b0, 3, 1'b1, 4'd1, 1'b1}); // BEQ taken
    tbl.push_back('{32'h00208463, 4'b0000, 1'b0, 3, 1'b1, 4'd1, 1'b0}); // BEQ not taken
    tbl.push_back('{32'h402081B3, 4'b0000, 1'b0, 4, 1'b1, 4'd1, 1'b0}); // SUB
    tbl.push_back('{32'h4020D1B3, 4'b0000, 1'b1, 4, 1'b1, 4'd7, 1'b0}); // SRA
    tbl.push_back('{32'h4050D193, 4'b1111, 1'b0, 4, 1'b1, 4'd7, 1'b0}); // SRAI, status ignored
    tbl.push_back('{32'h00502623, 4'b0000, 1'b1, 6, 1'b1, 4'd0, 1'b0}); // SW, wait 2
    tbl.push_back('{32'h00802283, 4'b0000, 1'b0, 5, 1'b1, 4'd0, 1'b0}); // LW, wait 0
    tbl.push_back('{32'h0020C463, 4'b1000, 1'b0, 3, 1'b1, 4'd1, 1'b1}); // BLT taken
    tbl.push_back('{32'h0020D463, 4'b1001, 1'b0, 3, 1'b1, 4'd1, 1'b1}); // BGE taken
    tbl.push_back('{32'h00209463, 4'b0100, 1'b1, 3, 1'b1, 4'd1, 1'b0}); // BNE not taken
    tbl.push_back('{32'hFFFFFFFF, 4'b0000, 1'b0, TRAP ? -1 : 2, 1'b0, 4'd0, 1'b0}); // illegal opcode
    tbl.push_back('{32'h0020A463, 4'b0000, 1'b1, TRAP ? -1 : 2, 1'b0, 4'd0, 1'b0}); // illegal branch funct3

    #3;
    check("reset_a", oa, exp_vec(0, 32'h0, 4'h0, 1'b0, 1'b0));
    check("reset_b", ob, exp_vec(0, 32'h0, 4'h0, 1'b0, 1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[n])
      run_instr(tbl[n].on_b, tbl[n].ins, tbl[n].st, tbl[n].cyc, tbl[n].chk, tbl[n].alu, tbl[n].pcsel);

    // Reset asserted in the middle of an LW MEM phase aborts with no strobes.
    instr = 32'h00802283; status = '0;
    run_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      @(posedge clk); #1;
      run_b = 1'b0;
    end
    check("in_mem", {14'd0, ob[16:14]}, 17'd3);
    #2;
    rst_n = 1'b0;
    run_b = 1'b1;
    #1;
    check("rst_mid_now", ob, exp_vec(0, instr, status, 1'b0, 1'b0));
    @(negedge clk);
    check("rst_mid_held", ob, exp_vec(0, instr, status, 1'b0, 1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("idle_after_rst", ob, exp_vec(0, instr, status, 1'b0, 1'b0));
      @(posedge clk); #1;
    end

    // Randomized instructions on both instances.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] r = $urandom;
      logic [6:0]  ops [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h00};
      logic [6:0]  f7s [3] = '{7'h00, 7'h20, 7'h00};
      int          oi = $urandom_range(0, 5);
      int          fi = $urandom_range(0, 2);
      r[6:0] = (oi == 5) ? 7'($urandom) : ops[oi];
      r[31:25] = (fi == 2) ? 7'($urandom) : f7s[fi];
      if ($urandom_range(0, 3) != 0 && (r[6:0] == 7'h03 || r[6:0] == 7'h23)) r[14:12] = 3'd2;
      run_instr(1'($urandom), r, 4'($urandom), -1, 1'b0, 4'd0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
